cpu31_ctrl: RTL and testbench
=============================

// Module: cpu31_ctrl
// PURPOSE
//  Multi-cycle control unit for the 31-instruction MIPS core; directly upstream of the ALU.
//  - Latches the instruction word and sequences FETCH/DECODE/EXEC/MEM/WB.
//  - Drives the ALU aluc[3:0], operand selects and all write enables.
//  - Consumes the ALU zero/overflow flags for branch resolution and overflow suppression.
// PARAMETERS
//  TRAP_ON_OVF  1  1: add/sub/addi overflow suppresses RF write and pulses exc_ovf; 0: always write
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst         in   1   asynchronous, active-high reset
//  instr       in   32  instruction word from IMEM
//  imem_ready  in   1   instr valid this cycle
//  dmem_ready  in   1   data access complete this cycle
//  alu_zero    in   1   ALU zero flag
//  alu_ovf     in   1   ALU overflow flag
//  ir          out  32  latched instruction register
//  aluc        out  4   ALU opcode
//  a_sel       out  1   0: ALU a=rs, 1: a=shamt (zero-extended ir[10:6])
//  b_sel       out  2   0: rt, 1: sign-ext imm16, 2: zero-ext imm16
//  pc_we       out  1   PC update strobe
//  pc_src      out  2   0: PC+4, 1: PC+4+(simm<<2), 2: {PC[31:28],ir[25:0],2'b0}, 3: rs
//  rf_we       out  1   register file write strobe
//  rf_wdst     out  2   0: rd, 1: rt, 2: $31
//  rf_wsrc     out  2   0: ALU r, 1: DMEM rdata, 2: PC+4
//  dm_re       out  1   DMEM read request (held until dmem_ready)
//  dm_we       out  1   DMEM write request (held until dmem_ready)
//  exc_ovf     out  1   one-cycle pulse on suppressed overflow
//  illegal     out  1   one-cycle pulse on undecodable instruction
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - state=FETCH, ir=0.
//    - pc_we, rf_we, dm_re, dm_we, exc_ovf, illegal all 0.
//    - aluc=4'b0000, selects 0.
//  - State and ir are registered; all other outputs decode combinationally from state, ir and flags.
//  - FETCH: wait while imem_ready=0. On imem_ready=1: ir<=instr, pc_we=1 with pc_src=0, go to DECODE.
//  - DECODE: j/jal/jr complete here.
//    - j: pc_we, pc_src=2.
//    - jal: additionally rf_we, rf_wdst=2, rf_wsrc=2.
//    - jr: pc_src=3.
//    - Then go to FETCH. All other legal instructions go to EXEC.
//    - Illegal opcode/funct: illegal=1 for one cycle, no writes, go to FETCH.
//  - EXEC: drive aluc per instruction:
//    - add/addi 0010; addu/addiu/lw/sw 0000; sub 0011; subu/beq/bne 0001.
//    - and/andi 0100; or/ori 0101; xor/xori 0110; nor 0111; lui 1000.
//    - slt/slti 1011; sltu/sltiu 1010.
//    - sra/srav 1100; srl/srlv 1101; sll/sllv 1110.
//    - a_sel=1 only for sll/srl/sra.
//    - b_sel=1 for addi/addiu/slti/sltiu/lw/sw; 2 for andi/ori/xori/lui.
//    - beq: pc_we=alu_zero, pc_src=1. bne: pc_we=~alu_zero. Either way go to FETCH.
//    - lw/sw go to MEM; everything else goes to WB.
//  - MEM: hold dm_re (lw) or dm_we (sw) until dmem_ready=1.
//    - lw then goes to WB; sw goes to FETCH.
//  - WB: rf_we=1.
//    - rf_wdst=0 for R-type, 1 for I-type/lw.
//    - rf_wsrc=1 for lw, else 0.
//    - aluc held from EXEC so ALU r remains valid.
//    - If TRAP_ON_OVF and alu_ovf and op is add/addi/sub: rf_we=0, exc_ovf=1.
//    - Go to FETCH.
//  - Latency with zero wait states:
//    - j/jal/jr 2 cycles; branch 3; R/I ALU 4; sw 4; lw 5.
//    - Each imem/dmem wait cycle adds 1.
//  - Writes to $0 are still issued; the register file discards them.
//  - rst asserted mid-instruction aborts immediately; no partial write strobes after reset.
//  - At most one of pc_we/rf_we/dm_we is asserted per cycle, except FETCH pc_we and jal (pc_we+rf_we).
// TESTING
//  - Reset mid-MEM with dm_we=1 -> dm_we drops to 0 same cycle; state=FETCH, ir=0 after release.
//  - addu $3,$1,$2 (0x00221821), imem_ready=1 -> aluc=0000 in EXEC; rf_we=1, rf_wdst=0 exactly 4 cycles after fetch.
//  - beq with alu_zero=1 -> EXEC pc_we=1, pc_src=1; with alu_zero=0 -> pc_we=0; both return to FETCH next cycle.
//  - lw with dmem_ready low 3 cycles -> dm_re held 4 cycles; then WB rf_wsrc=1, rf_wdst=1; total 8 cycles.
//  - add with alu_ovf=1, TRAP_ON_OVF=1 -> rf_we=0, exc_ovf single pulse in WB; TRAP_ON_OVF=0 -> rf_we=1.
//  - sll $2,$1,4 (0x00011100) -> aluc=1110, a_sel=1. Opcode 0x3F -> illegal pulse in DECODE, no writes.

Source files
------------

// File: rtl/cpu31_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the 31-instruction MIPS core.
// State and IR are registered; every other output is decoded from state, IR and ALU flags.
module cpu31_ctrl #(
    parameter bit TRAP_ON_OVF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    output logic [31:0] ir,
    output logic [3:0]  aluc,
    output logic        a_sel,
    output logic [1:0]  b_sel,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic [1:0]  rf_wdst,
    output logic [1:0]  rf_wsrc,
    output logic        dm_re,
    output logic        dm_we,
    output logic        exc_ovf,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    logic [5:0]  op, fn;
    logic        legal, isRtype, isJ, isJal, isJr, isBeq, isBne, isLw, isSw, isTrapOp;
    logic [3:0]  decAluc;
    logic        decAsel;
    logic [1:0]  decBsel;

    assign op      = ir_q[31:26];
    assign fn      = ir_q[5:0];
    assign isRtype = (op == 6'h00);
    assign ir      = ir_q;

    // Instruction decode table: ALU opcode, operand selects and instruction class.
    always_comb begin
        legal    = 1'b1;
        isJ      = 1'b0;
        isJal    = 1'b0;
        isJr     = 1'b0;
        isBeq    = 1'b0;
        isBne    = 1'b0;
        isLw     = 1'b0;
        isSw     = 1'b0;
        isTrapOp = 1'b0;
        decAluc  = 4'b0000;
        decAsel  = 1'b0;
        decBsel  = 2'd0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: begin decAluc = 4'b0010; isTrapOp = 1'b1; end
                    6'h21: decAluc = 4'b0000;
                    6'h22: begin decAluc = 4'b0011; isTrapOp = 1'b1; end
                    6'h23: decAluc = 4'b0001;
                    6'h24: decAluc = 4'b0100;
                    6'h25: decAluc = 4'b0101;
                    6'h26: decAluc = 4'b0110;
                    6'h27: decAluc = 4'b0111;
                    6'h2A: decAluc = 4'b1011;
                    6'h2B: decAluc = 4'b1010;
                    6'h00: begin decAluc = 4'b1110; decAsel = 1'b1; end
                    6'h02: begin decAluc = 4'b1101; decAsel = 1'b1; end
                    6'h03: begin decAluc = 4'b1100; decAsel = 1'b1; end
                    6'h04: decAluc = 4'b1110;
                    6'h06: decAluc = 4'b1101;
                    6'h07: decAluc = 4'b1100;
                    6'h08: isJr = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            6'h02: isJ = 1'b1;
            6'h03: isJal = 1'b1;
            6'h04: begin isBeq = 1'b1; decAluc = 4'b0001; end
            6'h05: begin isBne = 1'b1; decAluc = 4'b0001; end
            6'h08: begin decAluc = 4'b0010; decBsel = 2'd1; isTrapOp = 1'b1; end
            6'h09: begin decAluc = 4'b0000; decBsel = 2'd1; end
            6'h0A: begin decAluc = 4'b1011; decBsel = 2'd1; end
            6'h0B: begin decAluc = 4'b1010; decBsel = 2'd1; end
            6'h0C: begin decAluc = 4'b0100; decBsel = 2'd2; end
            6'h0D: begin decAluc = 4'b0101; decBsel = 2'd2; end
            6'h0E: begin decAluc = 4'b0110; decBsel = 2'd2; end
            6'h0F: begin decAluc = 4'b1000; decBsel = 2'd2; end
            6'h23: begin isLw = 1'b1; decAluc = 4'b0000; decBsel = 2'd1; end
            6'h2B: begin isSw = 1'b1; decAluc = 4'b0000; decBsel = 2'd1; end
            default: legal = 1'b0;
        endcase
    end

    // Sequencing and output strobes; rst forces every strobe low so an abort leaves no partial write.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        aluc    = 4'b0000;
        a_sel   = 1'b0;
        b_sel   = 2'd0;
        pc_we   = 1'b0;
        pc_src  = 2'd0;
        rf_we   = 1'b0;
        rf_wdst = 2'd0;
        rf_wsrc = 2'd0;
        dm_re   = 1'b0;
        dm_we   = 1'b0;
        exc_ovf = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = instr;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                if (!legal) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else if (isJ || isJal) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd2;
                    rf_we   = isJal;
                    rf_wdst = isJal ? 2'd2 : 2'd0;
                    rf_wsrc = isJal ? 2'd2 : 2'd0;
                    state_d = S_FETCH;
                end else if (isJr) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd3;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                aluc  = decAluc;
                a_sel = decAsel;
                b_sel = decBsel;
                if (isBeq || isBne) begin
                    pc_src  = 2'd1;
                    pc_we   = isBeq ? alu_zero : ~alu_zero;
                    state_d = S_FETCH;
                end else if (isLw || isSw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                aluc  = decAluc;
                a_sel = decAsel;
                b_sel = decBsel;
                dm_re = isLw;
                dm_we = isSw;
                if (dmem_ready) begin
                    state_d = isLw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                aluc    = decAluc;
                a_sel   = decAsel;
                b_sel   = decBsel;
                rf_wdst = isRtype ? 2'd0 : 2'd1;
                rf_wsrc = isLw ? 2'd1 : 2'd0;
                if (TRAP_ON_OVF && alu_ovf && isTrapOp) begin
                    exc_ovf = 1'b1;
                end else begin
                    rf_we = 1'b1;
                end
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            pc_we   = 1'b0;
            rf_we   = 1'b0;
            dm_re   = 1'b0;
            dm_we   = 1'b0;
            exc_ovf = 1'b0;
            illegal = 1'b0;
        end
    end

    // State and instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_cpu31_ctrl.sv
// Bench for cpu31_ctrl: an instruction-level model expands each instruction into its expected
// per-cycle output trace; two DUTs (overflow trap on/off) are checked against it every cycle.
module tb_cpu31_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        imem_ready, dmem_ready, alu_zero, alu_ovf;

    logic [31:0] irT, irN;
    logic [3:0]  alucT, alucN;
    logic        aSelT, aSelN, pcWeT, pcWeN, rfWeT, rfWeN;
    logic [1:0]  bSelT, bSelN, pcSrcT, pcSrcN, rfWdstT, rfWdstN, rfWsrcT, rfWsrcN;
    logic        dmReT, dmReN, dmWeT, dmWeN, excT, excN, illT, illN;

    typedef struct packed {
        logic       pcWe;
        logic [1:0] pcSrc;
        logic       rfWe;
        logic [1:0] rfWdst;
        logic [1:0] rfWsrc;
        logic       dmRe;
        logic       dmWe;
        logic       excOvf;
        logic       illegal;
        logic [3:0] aluc;
        logic       aSel;
        logic [1:0] bSel;
    } out_t;

    typedef struct {
        logic imemRdy;
        logic dmemRdy;
        out_t expT;
        out_t expN;
        logic checkIr;
    } cyc_t;

    typedef enum {
        M_ILL, M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
        M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_J, M_JAL, M_BEQ, M_BNE,
        M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW
    } mnem_t;

    out_t dutT, dutN;
    assign dutT = {pcWeT, pcSrcT, rfWeT, rfWdstT, rfWsrcT, dmReT, dmWeT, excT, illT, alucT, aSelT, bSelT};
    assign dutN = {pcWeN, pcSrcN, rfWeN, rfWdstN, rfWsrcN, dmReN, dmWeN, excN, illN, alucN, aSelN, bSelN};

    cyc_t        seq[$];
    out_t        gotT[$];
    out_t        gotN[$];
    logic [31:0] curInstr;
    logic        curZero, curOvf;
    int          testsRun = 0;
    int          testsFailed = 0;

    always #5 clk = ~clk;

    cpu31_ctrl #(.TRAP_ON_OVF(1'b1)) dutTrap (
        .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf), .ir(irT), .aluc(alucT), .a_sel(aSelT), .b_sel(bSelT),
        .pc_we(pcWeT), .pc_src(pcSrcT), .rf_we(rfWeT), .rf_wdst(rfWdstT), .rf_wsrc(rfWsrcT),
        .dm_re(dmReT), .dm_we(dmWeT), .exc_ovf(excT), .illegal(illT)
    );

    cpu31_ctrl #(.TRAP_ON_OVF(1'b0)) dutNoTrap (
        .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf), .ir(irN), .aluc(alucN), .a_sel(aSelN), .b_sel(bSelN),
        .pc_we(pcWeN), .pc_src(pcSrcN), .rf_we(rfWeN), .rf_wdst(rfWdstN), .rf_wsrc(rfWsrcN),
        .dm_re(dmReN), .dm_we(dmWeN), .exc_ovf(excN), .illegal(illN)
    );

    // Name the instruction from its MIPS encoding.
    function automatic mnem_t mnemonic(input logic [31:0] ins);
        mnem_t m = M_ILL;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h20: m = M_ADD;   6'h21: m = M_ADDU;  6'h22: m = M_SUB;  6'h23: m = M_SUBU;
                6'h24: m = M_AND;   6'h25: m = M_OR;    6'h26: m = M_XOR;  6'h27: m = M_NOR;
                6'h2A: m = M_SLT;   6'h2B: m = M_SLTU;  6'h00: m = M_SLL;  6'h02: m = M_SRL;
                6'h03: m = M_SRA;   6'h04: m = M_SLLV;  6'h06: m = M_SRLV; 6'h07: m = M_SRAV;
                6'h08: m = M_JR;
                default: m = M_ILL;
            endcase
        end else begin
            case (ins[31:26])
                6'h02: m = M_J;     6'h03: m = M_JAL;   6'h04: m = M_BEQ;  6'h05: m = M_BNE;
                6'h08: m = M_ADDI;  6'h09: m = M_ADDIU; 6'h0A: m = M_SLTI; 6'h0B: m = M_SLTIU;
                6'h0C: m = M_ANDI;  6'h0D: m = M_ORI;   6'h0E: m = M_XORI; 6'h0F: m = M_LUI;
                6'h23: m = M_LW;    6'h2B: m = M_SW;
                default: m = M_ILL;
            endcase
        end
        return m;
    endfunction

    function automatic logic [3:0] alucOf(input mnem_t m);
        case (m)
            M_ADD, M_ADDI:                 return 4'b0010;
            M_ADDU, M_ADDIU, M_LW, M_SW:   return 4'b0000;
            M_SUB:                         return 4'b0011;
            M_SUBU, M_BEQ, M_BNE:          return 4'b0001;
            M_AND, M_ANDI:                 return 4'b0100;
            M_OR, M_ORI:                   return 4'b0101;
            M_XOR, M_XORI:                 return 4'b0110;
            M_NOR:                         return 4'b0111;
            M_LUI:                         return 4'b1000;
            M_SLT, M_SLTI:                 return 4'b1011;
            M_SLTU, M_SLTIU:               return 4'b1010;
            M_SRA, M_SRAV:                 return 4'b1100;
            M_SRL, M_SRLV:                 return 4'b1101;
            M_SLL, M_SLLV:                 return 4'b1110;
            default:                       return 4'b0000;
        endcase
    endfunction

    function automatic out_t aluFields(input mnem_t m);
        out_t e = '0;
        e.aluc = alucOf(m);
        e.aSel = (m == M_SLL || m == M_SRL || m == M_SRA);
        case (m)
            M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_LW, M_SW: e.bSel = 2'd1;
            M_ANDI, M_ORI, M_XORI, M_LUI:                 e.bSel = 2'd2;
            default:                                      e.bSel = 2'd0;
        endcase
        return e;
    endfunction

    function automatic void pushCyc(input logic iRdy, input logic dRdy, input out_t eT, input out_t eN,
                                    input logic chkIr);
        cyc_t c;
        c.imemRdy = iRdy;
        c.dmemRdy = dRdy;
        c.expT    = eT;
        c.expN    = eN;
        c.checkIr = chkIr;
        seq.push_back(c);
    endfunction

    // Expand one instruction into its expected cycle-by-cycle trace.
    function automatic void buildSeq(input logic [31:0] ins, input int imemWait, input int dmemWait);
        mnem_t m = mnemonic(ins);
        out_t  e;
        out_t  eN;
        seq.delete();
        for (int i = 0; i < imemWait; i++) pushCyc(1'b0, 1'b1, '0, '0, 1'b0);
        e = '0;
        e.pcWe = 1'b1;
        pushCyc(1'b1, 1'b1, e, e, 1'b0);
        e = '0;
        case (m)
            M_J:   begin e.pcWe = 1'b1; e.pcSrc = 2'd2; end
            M_JAL: begin e.pcWe = 1'b1; e.pcSrc = 2'd2; e.rfWe = 1'b1; e.rfWdst = 2'd2; e.rfWsrc = 2'd2; end
            M_JR:  begin e.pcWe = 1'b1; e.pcSrc = 2'd3; end
            M_ILL: e.illegal = 1'b1;
            default: ;
        endcase
        pushCyc(1'b1, 1'b1, e, e, 1'b1);
        if (m == M_J || m == M_JAL || m == M_JR || m == M_ILL) return;
        e = aluFields(m);
        if (m == M_BEQ || m == M_BNE) begin
            e.pcSrc = 2'd1;
            e.pcWe  = (m == M_BEQ) ? curZero : ~curZero;
        end
        pushCyc(1'b1, 1'b1, e, e, 1'b1);
        if (m == M_BEQ || m == M_BNE) return;
        if (m == M_LW || m == M_SW) begin
            for (int i = 0; i <= dmemWait; i++) begin
                e = aluFields(m);
                e.dmRe = (m == M_LW);
                e.dmWe = (m == M_SW);
                pushCyc(1'b1, (i == dmemWait), e, e, 1'b1);
            end
            if (m == M_SW) return;
        end
        e = aluFields(m);
        e.rfWdst = (ins[31:26] == 6'h00) ? 2'd0 : 2'd1;
        e.rfWsrc = (m == M_LW) ? 2'd1 : 2'd0;
        eN = e;
        eN.rfWe = 1'b1;
        if (curOvf && (m == M_ADD || m == M_ADDI || m == M_SUB)) e.excOvf = 1'b1;
        else e.rfWe = 1'b1;
        pushCyc(1'b1, 1'b1, e, eN, 1'b1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic runSeq(input string name, input int limit);
        gotT.delete();
        gotN.delete();
        for (int k = 0; k < seq.size() && k < limit; k++) begin
            @(negedge clk);
            instr      = curInstr;
            imem_ready = seq[k].imemRdy;
            dmem_ready = seq[k].dmemRdy;
            alu_zero   = curZero;
            alu_ovf    = curOvf;
            #1;
            checkOutput($sformatf("%s trap c%0d", name, k), 32'(dutT), 32'(seq[k].expT));
            checkOutput($sformatf("%s notrap c%0d", name, k), 32'(dutN), 32'(seq[k].expN));
            if (seq[k].checkIr) begin
                checkOutput($sformatf("%s ir c%0d", name, k), irT, curInstr);
                checkOutput($sformatf("%s irN c%0d", name, k), irN, curInstr);
            end
            gotT.push_back(dutT);
            gotN.push_back(dutN);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] ins, input int imemWait,
                                 input int dmemWait, input logic zero, input logic ovf);
        curInstr = ins;
        curZero  = zero;
        curOvf   = ovf;
        buildSeq(ins, imemWait, dmemWait);
        runSeq(name, seq.size());
    endtask

    initial begin
        int nRe;
        logic [31:0] rList [8];
        rList = '{32'h00221822, 32'h00221823, 32'h00221824, 32'h00221825,
                  32'h0022182A, 32'h0022182B, 32'h00221807, 32'h00011102};
        rst = 1'b1; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0; alu_ovf = 1'b0;
        repeat (2) @(negedge clk);
        imem_ready = 1'b1;
        #1;
        checkOutput("reset outputs", 32'(dutT), 32'h0);
        checkOutput("reset ir", irT, 32'h0);
        rst = 1'b0;
        imem_ready = 1'b0;

        applyStimulus("addu", 32'h00221821, 0, 0, 1'b0, 1'b0);
        checkOutput("addu model len", seq.size(), 4);
        checkOutput("addu exec aluc", 32'(gotT[2].aluc), 32'h0);
        checkOutput("addu wb rf_we", 32'(gotT[3].rfWe), 32'h1);
        checkOutput("addu wb rf_wdst", 32'(gotT[3].rfWdst), 32'h0);

        applyStimulus("addu wait", 32'h00221821, 2, 0, 1'b0, 1'b0);
        checkOutput("addu wait model len", seq.size(), 6);

        applyStimulus("beq taken", 32'h10220003, 0, 0, 1'b1, 1'b0);
        checkOutput("beq model len", seq.size(), 3);
        checkOutput("beq taken pc_we", 32'(gotT[2].pcWe), 32'h1);
        checkOutput("beq taken pc_src", 32'(gotT[2].pcSrc), 32'h1);
        applyStimulus("beq not", 32'h10220003, 0, 0, 1'b0, 1'b0);
        checkOutput("beq not pc_we", 32'(gotT[2].pcWe), 32'h0);
        applyStimulus("bne taken", 32'h14220003, 0, 0, 1'b0, 1'b0);
        checkOutput("bne taken pc_we", 32'(gotT[2].pcWe), 32'h1);

        applyStimulus("lw", 32'h8C220004, 0, 3, 1'b0, 1'b0);
        checkOutput("lw model len", seq.size(), 8);
        nRe = 0;
        foreach (gotT[i]) if (gotT[i].dmRe) nRe++;
        checkOutput("lw dm_re cycles", nRe, 4);
        checkOutput("lw wb rf_wsrc", 32'(gotT[7].rfWsrc), 32'h1);
        checkOutput("lw wb rf_wdst", 32'(gotT[7].rfWdst), 32'h1);

        applyStimulus("sw", 32'hAC220004, 0, 0, 1'b0, 1'b0);
        checkOutput("sw model len", seq.size(), 4);

        applyStimulus("add ovf", 32'h00221820, 0, 0, 1'b0, 1'b1);
        checkOutput("add ovf exc", 32'(gotT[3].excOvf), 32'h1);
        checkOutput("add ovf rf_we", 32'(gotT[3].rfWe), 32'h0);
        checkOutput("add ovf notrap rf_we", 32'(gotN[3].rfWe), 32'h1);
        applyStimulus("add no ovf", 32'h00221820, 0, 0, 1'b0, 1'b0);
        applyStimulus("addi ovf", 32'h20220005, 0, 0, 1'b0, 1'b1);
        applyStimulus("addu ovf", 32'h00221821, 0, 0, 1'b0, 1'b1);

        applyStimulus("sll", 32'h00011100, 0, 0, 1'b0, 1'b0);
        checkOutput("sll aluc", 32'(gotT[2].aluc), 32'hE);
        checkOutput("sll a_sel", 32'(gotT[2].aSel), 32'h1);

        applyStimulus("op3f", 32'hFC000000, 0, 0, 1'b0, 1'b0);
        checkOutput("op3f model len", seq.size(), 2);
        checkOutput("op3f illegal", 32'(gotT[1].illegal), 32'h1);
        applyStimulus("bad funct", 32'h00000001, 0, 0, 1'b0, 1'b0);

        applyStimulus("j", 32'h08000010, 0, 0, 1'b0, 1'b0);
        applyStimulus("jal", 32'h0C000010, 1, 0, 1'b0, 1'b0);
        checkOutput("jal rf_wdst", 32'(gotT[2].rfWdst), 32'h2);
        applyStimulus("jr", 32'h03E00008, 0, 0, 1'b0, 1'b0);
        applyStimulus("ori", 32'h34220FF0, 0, 0, 1'b0, 1'b0);
        applyStimulus("lui", 32'h3C021234, 0, 0, 1'b0, 1'b0);
        checkOutput("lui aluc", 32'(gotT[2].aluc), 32'h8);
        applyStimulus("sltiu", 32'h2C220007, 0, 0, 1'b0, 1'b0);
        foreach (rList[i]) applyStimulus($sformatf("rtype%0d", i), rList[i], 0, 0, 1'b0, 1'b1);

        // Abort a store while it is stalled in MEM.
        curInstr = 32'hAC220004; curZero = 1'b0; curOvf = 1'b0;
        buildSeq(curInstr, 0, 5);
        runSeq("sw abort", 5);
        checkOutput("sw abort dm_we before", 32'(gotT[4].dmWe), 32'h1);
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        checkOutput("abort dm_we", 32'(dmWeT), 32'h0);
        checkOutput("abort outputs", 32'(dutT), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort ir", irT, 32'h0);
        checkOutput("abort fetch idle", 32'(dutT), 32'h0);
        applyStimulus("after abort", 32'h00221821, 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
